sine_rom_scheduler: RTL
=======================

# sine_rom_scheduler

Sequencer that shares one synchronous sine-table ROM (64 × 32-bit, one-cycle registered read) between N_CH PWM width channels. A free-running base address advances once per tick period. On each tick the block issues one ROM read per channel at a per-channel phase offset and collects the results in shadow registers. It then commits all widths together, so the PWM comparators always see a coherent, phase-aligned set (e.g. three-phase drive). It sits between the ROM and the per-channel PWM generators.

## Interface
Parameters:
- N_CH, 3: number of width channels (1..8)
- ADDR_W, 6: ROM address width
- DATA_W, 32: ROM data and width-output width
- TICK_MAX, 1000: clocks per table step; must be ≥ N_CH+3, elaboration error otherwise

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  runs the tick counter; low freezes it
- phase_ofs  in  N_CH*ADDR_W  per-channel address offset; channel i at bits [i*ADDR_W +: ADDR_W]; sampled per read
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  DATA_W  ROM output, valid the cycle after rom_en
- width  out  N_CH*DATA_W  committed widths; channel i at [i*DATA_W +: DATA_W]
- update  out  1  one-cycle pulse, high in the first cycle new widths are visible
- busy  out  1  high while not IDLE
- overrun  out  1  sticky; set when a tick arrives while busy; cleared only by reset

## Operation
- Tick counter `cnt` counts 0..TICK_MAX-1 while enable=1 and holds while enable=0. `tick` is high in a cycle with enable=1 and cnt=TICK_MAX-1; cnt then wraps to 0.
- On tick, `base` is incremented modulo 2^ADDR_W, regardless of state.
- FSM states:
  - IDLE: on tick → ISSUE with ch=0.
  - ISSUE: rom_en=1, rom_addr = base + ofs[ch] mod 2^ADDR_W, using the already-incremented base. ch increments each cycle; after ch=N_CH-1 → DRAIN.
  - DRAIN: captures the last channel's data → COMMIT.
  - COMMIT: width ← shadow, update ← 1 (registered) → IDLE.
- Capture: a one-cycle-delayed copy of rom_en plus a delayed channel index writes rom_data into shadow[ch_d].
- Once started, a sequence always completes, even if enable drops.
- A tick while busy: base still increments, no new sequence starts, overrun is set.
- rom_en is 0 outside ISSUE. rom_addr holds its last value.
- Reset mid-sequence aborts immediately. All state returns to reset values, and no update is emitted.

## Timing
- Reset values: width=0, update=0, rom_en=0, rom_addr=0, busy=0, overrun=0, base=0, cnt=0, state=IDLE.
- Tick in cycle T:
  - ISSUE occupies cycles T+1..T+N_CH.
  - DRAIN is cycle T+N_CH+1.
  - COMMIT is cycle T+N_CH+2.
  - width changes and update=1 in cycle T+N_CH+3.
- Latency from tick to update is N_CH+3 cycles.
- busy is high in cycles T+1..T+N_CH+2.
- First tick after reset with enable held high occurs in cycle TICK_MAX-1. Its reads use base=1.
- Address wrap: 63+1 → 0. Offsets wrap the same way.

## Structure
- Package sine_sched_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, COMMIT)
  - ROM_LATENCY=1
  - default ADDR_W and DATA_W constants
- One sub-module, sched_tick_gen: parameter TICK_MAX, ports clk, rst_n, enable, tick. It contains the counter with async reset.
- The FSM, base register, shadow array and capture pipeline live in the top module.

## Test plan
ROM model: data = addr × 16, one-cycle latency. Settings: N_CH=3, TICK_MAX=8, offsets {0,21,42}.

1. Reset, enable=1 → first tick at cycle 7; rom_addr 1,22,43 in cycles 8–10; update in cycle 13; width = {688,352,16}.
2. Run 64 ticks → base wraps 63→0; the read for channel 2 at base=30 uses address 8 (30+42=72 mod 64).
3. Drop enable during ISSUE → sequence completes and update fires; no further ticks occur; cnt holds its value.
4. Change phase_ofs during idle → the next sequence uses the new offsets; width is unchanged until update.
5. Assert rst_n=0 in the DRAIN cycle → all outputs are 0 next cycle; no update pulse follows.
6. Build with TICK_MAX=6 and N_CH=3, forcing a tick while busy via a bench-side tick override → overrun=1, base still advances, the in-flight sequence commits normally.

Source files
------------

// File: rtl/sine_sched_pkg.sv
// Shared types and constants for the sine-table ROM scheduler.
package sine_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam int ROM_LATENCY = 1;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 32;

endpackage

// File: rtl/sine_rom_scheduler_if.sv
// Read port of the shared synchronous sine ROM: scheduler is master, ROM is slave.
interface sine_rom_scheduler_if
  import sine_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);

endinterface

// File: rtl/sine_rom_scheduler_tick_gen.sv
// Table-step tick generator: counts 0..TICK_MAX-1 while enabled, holds otherwise.
module sched_tick_gen #(
  parameter int TICK_MAX = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // The counter wraps on its own compare, not on the tick output.
  assign wrap = (cnt_q == CNT_W'(TICK_MAX - 1));
  assign tick = enable && wrap;

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sine_rom_scheduler.sv
// Shares one sine ROM among N_CH PWM width channels; reads all channels per tick, commits together.
module sine_rom_scheduler
  import sine_sched_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TICK_MAX = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_CH*ADDR_W-1:0]   phase_ofs,
  sine_rom_scheduler_if.master     rom,
  output logic [N_CH*DATA_W-1:0]   width,
  output logic                     update,
  output logic                     busy,
  output logic                     overrun
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("sine_rom_scheduler: N_CH must be within 1..8");
  end
  if (TICK_MAX < N_CH + 3) begin : g_bad_tick_max
    $error("sine_rom_scheduler: TICK_MAX must be at least N_CH+3");
  end
  if (ROM_LATENCY != 1) begin : g_bad_latency
    $error("sine_rom_scheduler: capture pipeline assumes a one-cycle ROM");
  end

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [ADDR_W-1:0]       base_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    cap_en_q;
  logic [CH_W-1:0]         cap_ch_q;
  logic [DATA_W-1:0]       shadow_q [N_CH];
  logic [N_CH*DATA_W-1:0]  width_q;
  logic                    update_q;
  logic                    overrun_q;
  logic                    tick;
  logic                    rom_en_c;
  logic [ADDR_W-1:0]       rom_addr_c;

  sched_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // A started sequence always runs to COMMIT; enable only gates the tick source.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ISSUE;
          ch_d    = '0;
        end
      end
      ISSUE: begin
        if (ch_q == CH_W'(N_CH - 1)) state_d = DRAIN;
        else                         ch_d    = ch_q + CH_W'(1);
      end
      DRAIN:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outside ISSUE the address bus holds the last issued address.
  always_comb begin
    rom_en_c   = 1'b0;
    rom_addr_c = addr_q;
    busy       = (state_q != IDLE);
    if (state_q == ISSUE) begin
      rom_en_c   = 1'b1;
      rom_addr_c = base_q + phase_ofs[ch_q*ADDR_W +: ADDR_W];
    end
  end

  assign rom.rom_en   = rom_en_c;
  assign rom.rom_addr = rom_addr_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      addr_q    <= '0;
      cap_en_q  <= 1'b0;
      cap_ch_q  <= '0;
      width_q   <= '0;
      update_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (tick) base_q <= base_q + ADDR_W'(1);
      addr_q   <= rom_addr_c;
      cap_en_q <= rom_en_c;
      cap_ch_q <= ch_q;
      update_q <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        for (int i = 0; i < N_CH; i++) begin
          width_q[i*DATA_W +: DATA_W] <= shadow_q[i];
        end
      end
      if (tick && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  // NOTE: the shadow array has no reset; every entry is rewritten before any commit reads it.
  always_ff @(posedge clk) begin
    if (cap_en_q) shadow_q[cap_ch_q] <= rom.rom_data;
  end

  assign width   = width_q;
  assign update  = update_q;
  assign overrun = overrun_q;

endmodule
